ram_loader: RTL and testbench
=============================

Name: ram_loader

Overview:
- Writer-side counterpart to the team's parallel-read image ROM.
- Accepts a valid/ready word stream and writes it sequentially into an internal distributed RAM of 2**ADDR words.
- Exposes NUM combinational read ports so downstream conv/pool engines can read the image that was just loaded at runtime, with no $readmemb preload.
- Sits between the input DMA/stream source and the compute array; raises a done flag when the full image has been written.

Parameters:
WIDTH, 16, data word width in bits
NUM, 100, number of independent combinational read ports
ADDR, 10, address width; RAM depth is 2**ADDR words
LEN, 2**ADDR, words written per load; legal range 1..2**ADDR

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low
start  input  1  single-cycle request to begin a load
in_data  input  WIDTH  stream data word
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  loader accepts a word this cycle
busy  output  1  high while in LOAD
done  output  1  high from load completion until next start or reset
count  output  ADDR+1  number of words written in the current or last load
address  input  ADDR x NUM (unpacked [0:NUM-1])  read address per port
rd_data  output  WIDTH x NUM (unpacked [0:NUM-1])  read data per port

Behaviour:
- Reset (rst low at a rising edge):
  - state to IDLE; write pointer, count, busy and done to 0.
  - in_ready is 0 while in reset.
  - RAM contents are NOT cleared; words already written survive a reset.
- States and transitions:
  - IDLE: start=1 -> LOAD at next edge; write pointer and count cleared at that edge.
  - LOAD: busy=1, in_ready=1 (in_ready decoded directly from state, no extra delay).
    - Each edge with in_valid=1: mem[wr_ptr] <= in_data; wr_ptr and count increment.
    - The beat written when count==LEN-1 moves the FSM to DONE at that same edge. done=1 and busy=0 from the following cycle; count==LEN.
  - DONE: done held high, in_ready=0. start=1 -> LOAD at next edge, with done cleared, wr_ptr=0 and count=0 at that edge.
- start while in LOAD is ignored; there is no restart mid-load.
- in_valid while not in LOAD is ignored; no write, count unchanged.
- No back-pressure inside LOAD: every valid beat is accepted. in_valid gaps simply stall the pointer.
- LEN=2**ADDR: wr_ptr wraps to 0 after the last beat. No write occurs at the wrap, because the FSM has already left LOAD.
- Reads:
  - rd_data[i] = mem[address[i]], purely combinational, zero latency, all NUM ports independent.
  - A read of the address being written in the same cycle returns the old word; the new word is visible from the cycle after the edge.
  - Addresses >= LEN return whatever that location holds: stale, or X if never written.
- Reset mid-load: FSM to IDLE, done=0, count=0. Partially written words are retained; the next start overwrites from address 0.
- Simultaneous events:
  - rst low has priority over start and in_valid.
  - In DONE, a start together with in_valid does not write in_valid's word; the first accepted word is the first valid beat after entering LOAD.
- The memory array is marked distributed RAM style: one write port, NUM asynchronous read ports.

Test Plan:
Bench parameters: WIDTH=8, NUM=4, ADDR=3, LEN=8.
1. Reset, pulse start, stream 0x10..0x17 back-to-back. Required:
   - in_ready=1 for 8 cycles; count increments 1..8.
   - done=1 and busy=0 on the cycle after the 8th beat.
   - Ports 0..3 at addresses 0,3,5,7 read 0x10,0x13,0x15,0x17 combinationally.
2. Stream with in_valid toggling 1,0,1,0 for 8 words. Required: count advances only on valid beats; done rises exactly after the 8th valid beat; contents match the input order.
3. Drive address[0]=2 while the beat for address 2 (0xAA, overwriting 0x12) is accepted. Required: rd_data[0]=0x12 in that cycle, 0xAA the next cycle.
4. Pulse rst low after 4 beats of a load. Required:
   - busy=0, done=0, count=0 next cycle; addresses 0..3 still hold the written words.
   - A new start plus 8 words yields done with the new data.
5. In DONE, pulse start with in_valid=1 and in_data=0x55. Required: done=0 next cycle and no write that cycle; the following 8 beats 0x20..0x27 land at addresses 0..7.
6. Drive in_valid=1 in IDLE and in DONE, and pulse start mid-LOAD. Required: no writes, count unchanged, and the load continues uninterrupted to done after 8 beats total.

Source files
------------

// File: rtl/ram_loader_if.sv
// ram_loader_if: stream handshake bundle feeding ram_loader.
//   start    : single-cycle request to begin a load (source -> loader)
//   in_data  : stream data word, WIDTH bits (source -> loader)
//   in_valid : in_data is valid this cycle (source -> loader)
//   in_ready : loader accepts a word this cycle (loader -> source)
// master modport is the stream source, slave modport is the loader.
interface ram_loader_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output start, output in_data, output in_valid, input in_ready);
  modport slave  (input start, input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ram_loader.sv
// ram_loader: writes a valid/ready word stream sequentially into a
// distributed RAM of 2**ADDR words and exposes NUM independent
// combinational read ports over the freshly loaded image.
// Ports:
//   clk     : system clock, rising edge
//   rst     : synchronous reset, active-low (RAM contents are kept)
//   stream  : slave side of ram_loader_if (start, in_data, in_valid, in_ready)
//   busy    : high while loading
//   done    : high from load completion until the next start or reset
//   count   : words written in the current or last load
//   address : per-port read address
//   rd_data : per-port read data, zero latency
module ram_loader #(
  parameter int WIDTH = 16,
  parameter int NUM   = 100,
  parameter int ADDR  = 10,
  parameter int LEN   = 2**ADDR
) (
  input  logic             clk,
  input  logic             rst,
  ram_loader_if.slave      stream,
  output logic             busy,
  output logic             done,
  output logic [ADDR:0]    count,
  input  logic [ADDR-1:0]  address [0:NUM-1],
  output logic [WIDTH-1:0] rd_data [0:NUM-1]
);

  localparam int            DEPTH = 1 << ADDR;
  localparam logic [ADDR:0] LAST  = (ADDR+1)'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [ADDR-1:0] wr_ptr;
  logic            wr_en;
  logic            start_load;

  (* ram_style = "distributed" *)
  logic [WIDTH-1:0] mem [0:DEPTH-1];

  // Decode: accept, write and start conditions. rst gating keeps reset
  // priority over in_valid even while the state register still reads LOAD.
  always_comb begin
    state_next      = state;
    busy            = 1'b0;
    done            = 1'b0;
    stream.in_ready = 1'b0;
    wr_en           = 1'b0;
    start_load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (stream.start) begin
          state_next = LOAD;
          start_load = 1'b1;
        end
      end
      LOAD: begin
        busy            = 1'b1;
        stream.in_ready = rst;
        wr_en           = rst & stream.in_valid;
        // The beat that completes the image leaves LOAD at this same edge.
        if (wr_en && (count == LAST)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (stream.start) begin
          state_next = LOAD;
          start_load = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control registers: state, write pointer and word count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      if (start_load) begin
        wr_ptr <= '0;
        count  <= '0;
      end else if (wr_en) begin
        // For LEN == DEPTH the pointer wraps to 0 on the last beat.
        wr_ptr <= wr_ptr + ADDR'(1);
        count  <= count + (ADDR+1)'(1);
      end
    end
  end

  // Storage: single write port, never reset so a reset keeps the image.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= stream.in_data;
    end
  end

  // Asynchronous read ports; a same-cycle write shows up after the edge.
  for (genvar i = 0; i < NUM; i++) begin : g_rd
    assign rd_data[i] = mem[address[i]];
  end

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: self-checking bench for ram_loader (WIDTH=8, NUM=4,
// ADDR=3, LEN=8). A word-level model (load flag, done flag, words
// written, image array) tracks the expected outputs; a compare process
// checks every cycle, and directed sequences pin literal values.
module tb_ram_loader;
  localparam int WIDTH = 8;
  localparam int NUM   = 4;
  localparam int ADDR  = 3;
  localparam int LEN   = 8;

  logic             clk;
  logic             rst;
  logic             busy;
  logic             done;
  logic [ADDR:0]    count;
  logic [ADDR-1:0]  address [0:NUM-1];
  logic [WIDTH-1:0] rd_data [0:NUM-1];

  ram_loader_if #(.WIDTH(WIDTH)) bus ();

  ram_loader #(.WIDTH(WIDTH), .NUM(NUM), .ADDR(ADDR), .LEN(LEN)) dut (
    .clk     (clk),
    .rst     (rst),
    .stream  (bus),
    .busy    (busy),
    .done    (done),
    .count   (count),
    .address (address),
    .rd_data (rd_data)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit         m_load  = 0;
  bit         m_done  = 0;
  int         m_cnt   = 0;
  logic [7:0] mmem  [8];
  bit         known [8];

  bit         rand_addr = 1;
  logic [7:0] words [8];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1;
    tick();
    bus.start = 0;
  endtask

  task automatic stream8();
    bus.in_valid = 1;
    for (int k = 0; k < 8; k++) begin
      bus.in_data = words[k];
      tick();
    end
    bus.in_valid = 0;
  endtask

  task automatic check_contents(input int lo, input string name);
    rand_addr = 0;
    for (int i = 0; i < NUM; i++) address[i] = ADDR'(lo + i);
    #1;
    for (int i = 0; i < NUM; i++) chk($sformatf("%s_rd%0d", name, lo + i), rd_data[i], words[lo + i]);
    rand_addr = 1;
  endtask

  // Model: the k-th accepted word of a load lands at address k.
  always @(posedge clk) begin
    if (!rst) begin
      m_load <= 0;
      m_done <= 0;
      m_cnt  <= 0;
    end else if (m_load) begin
      if (bus.in_valid) begin
        mmem[m_cnt % 8]  <= bus.in_data;
        known[m_cnt % 8] <= 1;
        m_cnt            <= m_cnt + 1;
        if (m_cnt == LEN - 1) begin
          m_load <= 0;
          m_done <= 1;
        end
      end
    end else if (bus.start) begin
      m_load <= 1;
      m_done <= 0;
      m_cnt  <= 0;
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("busy", busy, m_load);
    chk("done", done, m_done);
    chk("count", count, m_cnt);
    chk("in_ready", bus.in_ready, m_load && rst);
    for (int i = 0; i < NUM; i++) begin
      if (known[address[i]]) chk($sformatf("rd%0d", i), rd_data[i], mmem[address[i]]);
    end
  end

  // Random read addresses each cycle unless a directed check owns them.
  always @(posedge clk) begin
    #2;
    if (rand_addr) begin
      for (int i = 0; i < NUM; i++) address[i] = ADDR'($urandom_range(0, 7));
    end
  end

  initial begin
    logic [7:0] prev0;
    int idx;
    rst = 0;
    bus.start = 0;
    bus.in_valid = 0;
    bus.in_data = 0;
    for (int i = 0; i < NUM; i++) address[i] = '0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", bus.in_ready, 0);

    // 1: back-to-back load 0x10..0x17
    rst = 1;
    tick();
    pulse_start();
    bus.in_valid = 1;
    for (int k = 0; k < 8; k++) begin
      bus.in_data = 8'(8'h10 + k);
      @(negedge clk);
      chk("t1_ready", bus.in_ready, 1);
      chk("t1_count", count, k);
      tick();
    end
    bus.in_valid = 0;
    rand_addr = 0;
    address[0] = 0; address[1] = 3; address[2] = 5; address[3] = 7;
    @(negedge clk);
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_count8", count, 8);
    chk("t1_model_cnt", m_cnt, 8);
    chk("t1_rd0", rd_data[0], 8'h10);
    chk("t1_rd1", rd_data[1], 8'h13);
    chk("t1_rd2", rd_data[2], 8'h15);
    chk("t1_rd3", rd_data[3], 8'h17);

    // 3: read-during-write returns the old word
    address[0] = 2;
    pulse_start();
    bus.in_valid = 1;
    for (int k = 0; k < 8; k++) begin
      bus.in_data = (k == 2) ? 8'hAA : 8'(8'h30 + k);
      @(negedge clk);
      if (k == 2) chk("t3_old", rd_data[0], 8'h12);
      if (k == 3) chk("t3_new", rd_data[0], 8'hAA);
      tick();
    end
    bus.in_valid = 0;
    rand_addr = 1;
    @(negedge clk);
    chk("t3_done", done, 1);

    // 2: in_valid toggling 1,0,1,0
    for (int k = 0; k < 8; k++) words[k] = 8'($urandom);
    pulse_start();
    for (int j = 0; j < 15; j++) begin
      bus.in_valid = (j % 2 == 0);
      bus.in_data = bus.in_valid ? words[j / 2] : 8'($urandom);
      @(negedge clk);
      chk("t2_done_early", done, 0);
      chk("t2_count", count, (j + 1) / 2);
      tick();
    end
    bus.in_valid = 0;
    @(negedge clk);
    chk("t2_done", done, 1);
    check_contents(0, "t2");
    check_contents(4, "t2");

    // 4: reset mid-load keeps written words, with in_valid high during reset
    for (int k = 0; k < 8; k++) words[k] = 8'($urandom);
    pulse_start();
    bus.in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      bus.in_data = words[k];
      tick();
    end
    rst = 0;
    bus.in_data = 8'($urandom);
    tick();
    rst = 1;
    bus.in_valid = 0;
    @(negedge clk);
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    chk("t4_count", count, 0);
    check_contents(0, "t4_kept");
    for (int k = 0; k < 8; k++) words[k] = 8'($urandom);
    pulse_start();
    stream8();
    @(negedge clk);
    chk("t4_redone", done, 1);
    check_contents(0, "t4_new");
    check_contents(4, "t4_new");

    // 5: start with in_valid in DONE does not write
    prev0 = words[0];
    bus.start = 1;
    bus.in_valid = 1;
    bus.in_data = 8'h55;
    tick();
    bus.start = 0;
    bus.in_valid = 0;
    @(negedge clk);
    chk("t5_done", done, 0);
    chk("t5_busy", busy, 1);
    chk("t5_count", count, 0);
    rand_addr = 0;
    address[0] = 0;
    #1;
    chk("t5_nowrite", rd_data[0], prev0);
    rand_addr = 1;
    for (int k = 0; k < 8; k++) words[k] = 8'(8'h20 + k);
    stream8();
    @(negedge clk);
    chk("t5_done2", done, 1);
    check_contents(0, "t5");
    check_contents(4, "t5");

    // 6: in_valid in DONE / IDLE ignored, start mid-load ignored
    bus.in_valid = 1;
    repeat (3) begin
      bus.in_data = 8'($urandom);
      tick();
    end
    @(negedge clk);
    chk("t6_done_cnt", count, 8);
    rst = 0;
    bus.in_valid = 0;
    tick();
    rst = 1;
    bus.in_valid = 1;
    repeat (3) begin
      bus.in_data = 8'($urandom);
      tick();
    end
    @(negedge clk);
    chk("t6_idle_cnt", count, 0);
    chk("t6_idle_busy", busy, 0);
    bus.in_valid = 0;
    for (int k = 0; k < 8; k++) words[k] = 8'($urandom);
    pulse_start();
    idx = 0;
    for (int j = 0; j < 12 && idx < 8; j++) begin
      bus.in_valid = (j != 3);
      bus.start = (j == 2 || j == 5);
      bus.in_data = bus.in_valid ? words[idx] : 8'($urandom);
      if (bus.in_valid) idx++;
      tick();
    end
    bus.in_valid = 0;
    bus.start = 0;
    @(negedge clk);
    chk("t6_done", done, 1);
    chk("t6_count", count, 8);
    check_contents(0, "t6");
    check_contents(4, "t6");

    // Random traffic against the model
    rand_addr = 1;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom % 32) != 0;
      bus.start = ($urandom % 8) == 0;
      bus.in_valid = $urandom % 2;
      bus.in_data = 8'($urandom);
      tick();
    end
    rst = 1;
    bus.start = 0;
    bus.in_valid = 0;
    tick();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
